// File: rtl/fpdiv_nr_param.sv
// Multi-cycle Newton-Raphson divider on sign-magnitude fixed point: ans = 1/den or num/den,
// with divide-by-zero and overflow flags, saturation and a busy/done handshake.
module fpdiv_nr_param #(
    parameter int N    = 32,
    parameter int Q    = 16,
    parameter int ITER = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         startdiv,
    input  logic         mode,
    input  logic [N-1:0] num,
    input  logic [N-1:0] den,
    output logic [N-1:0] ans,
    output logic         donediv,
    output logic         busy,
    output logic         divzero,
    output logic         ovf
);
    localparam int M  = N - 1;
    localparam int CW = $clog2(N);
    localparam int IW = 4;

    localparam longint          K0_L = (48 * (longint'(1) << Q) + 8) / 17;
    localparam longint          K1_L = (32 * (longint'(1) << Q) + 8) / 17;
    localparam logic [M-1:0]    K0   = K0_L[M-1:0];
    localparam logic [M-1:0]    K1   = K1_L[M-1:0];
    localparam logic [M-1:0]    ONE  = M'(1) << Q;
    localparam logic [M-1:0]    HALF = M'(1) << (Q - 1);
    localparam logic [M-1:0]    TWO  = M'(2) << Q;
    localparam logic [M-1:0]    SAT  = '1;

    typedef enum logic [3:0] {
        IDLE, LOAD, NORM, EST1, EST2, IT_MUL1, IT_SUB, IT_MUL2, SCALE, MULNUM, DONE
    } state_t;

    state_t        state, state_next;
    logic          mode_r, num_s, sgn, dir_l;
    logic [N-1:0]  den_l;
    logic [M-1:0]  num_l, d, x, m, t;
    logic [CW-1:0] cnt;
    logic [IW-1:0] it;

    logic [M-1:0]   mul_a, mul_b, scale_res, mul_res, fin_res;
    logic [2*M-1:0] prod, prod_sh, wide_l;
    logic           scale_ovf, mul_ovf;

    assign busy = (state != IDLE);

    // One shared multiplier, operands steered by state.
    always_comb begin
        mul_a = x;
        mul_b = t;
        case (state)
            EST1:    begin mul_a = K1; mul_b = d;     end
            IT_MUL1: begin mul_a = d;  mul_b = x;     end
            MULNUM:  begin mul_a = x;  mul_b = num_l; end
            default: ;
        endcase
    end

    assign prod    = {{M{1'b0}}, mul_a} * {{M{1'b0}}, mul_b};
    assign prod_sh = prod >> Q;
    assign mul_ovf = |prod_sh[2*M-1:M];
    assign mul_res = mul_ovf ? SAT : prod_sh[M-1:0];

    // Undo normalisation; a zero divisor arrives here with cnt=0 and saturates directly.
    always_comb begin
        wide_l    = {{M{1'b0}}, x} << cnt;
        scale_ovf = !divzero && dir_l && (|wide_l[2*M-1:M]);
        if (divzero || scale_ovf) scale_res = SAT;
        else if (dir_l)           scale_res = wide_l[M-1:0];
        else                      scale_res = x >> cnt;
        fin_res = (state == MULNUM) ? mul_res : scale_res;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (startdiv) state_next = LOAD;
            LOAD:    state_next = (den_l[M-1:0] == '0) ? SCALE : NORM;
            NORM:    if (d <= ONE && d >= HALF) state_next = EST1;
            EST1:    state_next = EST2;
            EST2:    state_next = IT_MUL1;
            IT_MUL1: state_next = IT_SUB;
            IT_SUB:  state_next = IT_MUL2;
            IT_MUL2: state_next = (it == IW'(ITER - 1)) ? SCALE : IT_MUL1;
            SCALE:   state_next = (mode_r && !divzero) ? MULNUM : DONE;
            MULNUM:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ans     <= '0;
            donediv <= 1'b0;
            divzero <= 1'b0;
            ovf     <= 1'b0;
            mode_r  <= 1'b0;
            num_s   <= 1'b0;
            sgn     <= 1'b0;
            dir_l   <= 1'b0;
            den_l   <= '0;
            num_l   <= '0;
            d       <= '0;
            x       <= '0;
            m       <= '0;
            t       <= '0;
            cnt     <= '0;
            it      <= '0;
        end else begin
            state   <= state_next;
            donediv <= 1'b0;
            case (state)
                IDLE: if (startdiv) begin
                    mode_r <= mode;
                    num_s  <= num[N-1];
                    num_l  <= num[M-1:0];
                    den_l  <= den;
                end
                LOAD: begin
                    sgn     <= mode_r ? (num_s ^ den_l[N-1]) : den_l[N-1];
                    d       <= den_l[M-1:0];
                    cnt     <= '0;
                    it      <= '0;
                    dir_l   <= 1'b0;
                    ovf     <= 1'b0;
                    divzero <= (den_l[M-1:0] == '0);
                end
                NORM: begin
                    if (d > ONE) begin
                        d     <= d >> 1;
                        cnt   <= cnt + 1'b1;
                        dir_l <= 1'b0;
                    end else if (d < HALF) begin
                        d     <= d << 1;
                        cnt   <= cnt + 1'b1;
                        dir_l <= 1'b1;
                    end
                end
                EST1:    m <= prod_sh[M-1:0];
                EST2:    x <= K0 - m;
                IT_MUL1: m <= prod_sh[M-1:0];
                IT_SUB:  t <= TWO - m;
                IT_MUL2: begin
                    x  <= prod_sh[M-1:0];
                    it <= it + 1'b1;
                end
                SCALE, MULNUM: begin
                    x <= fin_res;
                    if ((state == SCALE && scale_ovf) || (state == MULNUM && mul_ovf))
                        ovf <= 1'b1;
                    if (state_next == DONE) begin
                        // A zero magnitude never carries a sign.
                        ans     <= {sgn && (fin_res != '0), fin_res};
                        donediv <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpdiv_nr_param.sv
// Directed checks of fpdiv_nr_param: reset, reciprocal, division, zero divisor, saturation,
// abort by reset, ignored start while busy, and back-to-back operations.
module tb_fpdiv_nr_param;
    logic        clk = 1'b0;
    logic        rst, startdiv, mode;
    logic [31:0] num, den, ans;
    logic        donediv, busy, divzero, ovf;
    int          checks = 0;
    int          errors = 0;

    fpdiv_nr_param #(.N(32), .Q(16), .ITER(4)) dut (
        .clk(clk), .rst(rst), .startdiv(startdiv), .mode(mode), .num(num), .den(den),
        .ans(ans), .donediv(donediv), .busy(busy), .divzero(divzero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic bit near(input logic [31:0] a, input logic [31:0] e);
        int da;
        if (a[31] !== e[31]) return 1'b0;
        da = int'(a[30:0]) - int'(e[30:0]);
        return (da <= 2 && da >= -2);
    endfunction

    // Starts one operation from IDLE and returns the edge count (edge 0 samples startdiv)
    // after which donediv was seen; lat=-1 if it never came.
    task automatic run_op(input logic md, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin @(negedge clk); guard++; end
        mode = md; num = a; den = b; startdiv = 1'b1;
        @(posedge clk); #1;
        startdiv = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (donediv) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; startdiv = 1'b0; mode = 1'b0; num = '0; den = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ans !== 32'h0)   begin errors++; $display("FAIL reset_ans got %h want 00000000", ans); end
        checks++; if (donediv !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", donediv); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({divzero, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {divzero, ovf}); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_recip();
        int lat;
        run_op(1'b0, 32'h0, 32'h0004_0000, lat);
        checks++; if (!near(ans, 32'h0000_4000)) begin errors++; $display("FAIL recip4_ans got %h want 00004000+-2", ans); end
        checks++; if (lat !== 19) begin errors++; $display("FAIL recip4_latency got %0d want 19", lat); end
        checks++; if ({divzero, ovf} !== 2'b00) begin errors++; $display("FAIL recip4_flags got %b want 00", {divzero, ovf}); end
        @(posedge clk); #1;
        checks++; if ({donediv, busy} !== 2'b00) begin errors++; $display("FAIL done_pulse got %b want 00", {donediv, busy}); end
        run_op(1'b0, 32'h0, 32'h8002_0000, lat);
        checks++; if (!near(ans, 32'h8000_8000)) begin errors++; $display("FAIL recip_neg2_ans got %h want 80008000+-2", ans); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL recip_neg2_latency got %0d want 18", lat); end
    endtask

    task automatic test_div();
        int lat;
        run_op(1'b1, 32'h0003_0000, 32'h0001_8000, lat);
        checks++; if (!near(ans, 32'h0002_0000)) begin errors++; $display("FAIL div3_1p5_ans got %h want 00020000+-2", ans); end
        checks++; if (lat !== 19) begin errors++; $display("FAIL div3_1p5_latency got %0d want 19", lat); end
        run_op(1'b1, 32'h8000_0000, 32'h0001_0000, lat);
        checks++; if (ans !== 32'h0) begin errors++; $display("FAIL div_zero_num got %h want 00000000", ans); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL div_zero_num_latency got %0d want 18", lat); end
    endtask

    task automatic test_divzero();
        int lat;
        run_op(1'b0, 32'h0, 32'h0000_0000, lat);
        checks++; if (ans !== 32'h7FFF_FFFF) begin errors++; $display("FAIL dz_pos_ans got %h want 7fffffff", ans); end
        checks++; if ({divzero, ovf} !== 2'b10) begin errors++; $display("FAIL dz_pos_flags got %b want 10", {divzero, ovf}); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL dz_pos_latency got %0d want 2", lat); end
        run_op(1'b0, 32'h0, 32'h8000_0000, lat);
        checks++; if (ans !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_neg_ans got %h want ffffffff", ans); end
        checks++; if (divzero !== 1'b1) begin errors++; $display("FAIL dz_neg_flag got %b want 1", divzero); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL dz_neg_latency got %0d want 2", lat); end
    endtask

    task automatic test_ovf();
        int lat;
        run_op(1'b0, 32'h0, 32'h0000_0001, lat);
        checks++; if (ans !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_recip_ans got %h want 7fffffff", ans); end
        checks++; if ({divzero, ovf} !== 2'b01) begin errors++; $display("FAIL ovf_recip_flags got %b want 01", {divzero, ovf}); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL ovf_recip_latency got %0d want 32", lat); end
        run_op(1'b1, 32'h7FFF_0000, 32'h0000_8000, lat);
        checks++; if (ans !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_div_ans got %h want 7fffffff", ans); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_div_flag got %b want 1", ovf); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL ovf_div_latency got %0d want 18", lat); end
    endtask

    task automatic test_abort();
        int seen = 0;
        @(negedge clk);
        while (busy) @(negedge clk);
        mode = 1'b0; den = 32'h0004_0000; startdiv = 1'b1;
        @(posedge clk); #1;
        startdiv = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (ans !== 32'h0) begin errors++; $display("FAIL abort_ans got %h want 00000000", ans); end
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (donediv || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d cycles active want 0", seen); end
    endtask

    task automatic test_busy_ignore();
        int lat = -1;
        int late = 0;
        @(negedge clk);
        while (busy) @(negedge clk);
        mode = 1'b0; den = 32'h0004_0000; startdiv = 1'b1;
        @(posedge clk); #1;
        startdiv = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin startdiv = 1'b1; mode = 1'b1; den = 32'h0; end
            if (k == 4) startdiv = 1'b0;
            if (donediv) begin lat = k; break; end
        end
        checks++; if (!near(ans, 32'h0000_4000)) begin errors++; $display("FAIL ignore_ans got %h want 00004000+-2", ans); end
        checks++; if (lat !== 19) begin errors++; $display("FAIL ignore_latency got %0d want 19", lat); end
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL ignore_divzero got %b want 0", divzero); end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (busy) late++;
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL ignore_not_queued got %0d busy cycles want 0", late); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(1'b0, 32'h0, 32'h0002_0000, lat);
        checks++; if (!near(ans, 32'h0000_8000) || lat !== 18) begin errors++; $display("FAIL b2b_first got %h lat %0d want 00008000+-2 lat 18", ans, lat); end
        run_op(1'b0, 32'h0, 32'h0000_8000, lat);
        checks++; if (!near(ans, 32'h0002_0000) || lat !== 17) begin errors++; $display("FAIL b2b_second got %h lat %0d want 00020000+-2 lat 17", ans, lat); end
        run_op(1'b0, 32'h0, 32'h0, lat);
        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, lat);
        checks++; if (!near(ans, 32'h0001_0000) || divzero !== 1'b0) begin errors++; $display("FAIL b2b_clear_dz got %h dz %b want 00010000+-2 dz 0", ans, divzero); end
    endtask

    initial begin
        test_reset();
        test_recip();
        test_div();
        test_divzero();
        test_ovf();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
